// File: rtl/mdr_access_controller.sv
// MDR source-select and memory handshake sequencer.
// Runs read (mem -> M bus -> MDR) and store (S bus -> MDR -> mem) transactions.
module mdr_access_controller #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_start,
    input  logic wr_start,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_we,
    output logic MMD,
    output logic SMD,
    output logic busy,
    output logic done,
    output logic timeout_err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_REQ   = 3'd1;
    localparam logic [2:0] RD_LATCH = 3'd2;
    localparam logic [2:0] WR_LOAD  = 3'd3;
    localparam logic [2:0] WR_REQ   = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;
    localparam logic [2:0] ABORT    = 3'd6;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ack in the last allowed wait cycle still counts as success.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rd_start) begin
                    state_d = RD_REQ;
                    cnt_d   = '0;
                end else if (wr_start) begin
                    state_d = WR_LOAD;
                end
            end
            RD_REQ: begin
                if (mem_ack)            state_d = RD_LATCH;
                else if (cnt_q == LAST) state_d = ABORT;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            RD_LATCH: state_d = DONE;
            WR_LOAD: begin
                state_d = WR_REQ;
                cnt_d   = '0;
            end
            WR_REQ: begin
                if (mem_ack)            state_d = DONE;
                else if (cnt_q == LAST) state_d = ABORT;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        MMD         = 1'b0;
        SMD         = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        busy        = (state_q != IDLE);
        unique case (state_q)
            RD_REQ:   mem_req = 1'b1;
            RD_LATCH: MMD = 1'b1;
            WR_LOAD:  SMD = 1'b1;
            WR_REQ: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            DONE:     done = 1'b1;
            ABORT:    timeout_err = 1'b1;
            default: ;
        endcase
    end

    a_sel_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(MMD && SMD));
    a_sel_noreq: assert property (@(posedge clk) disable iff (!rst_n)
        !((MMD || SMD) && mem_req));
    a_we_req: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_we && !mem_req));
    a_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(done && timeout_err));

endmodule

// File: tb/tb_mdr_access_controller.sv
// Scoreboard bench for mdr_access_controller: expected output vectors are
// queued with each stimulus cycle and compared once the DUT has clocked.
module tb_mdr_access_controller;

    logic clk = 1'b0;
    logic rst_n, rd_start, wr_start, mem_ack;
    logic mem_req, mem_we, MMD, SMD, busy, done, timeout_err;
    logic [7:0] mbus, sbus, mdr;

    int checks = 0;
    int failures = 0;
    logic [6:0] exp_q[$];

    // {mem_req, mem_we, MMD, SMD, busy, done, timeout_err}
    localparam logic [6:0] E_IDLE  = 7'b0000000;
    localparam logic [6:0] E_RDREQ = 7'b1000100;
    localparam logic [6:0] E_RDLAT = 7'b0010100;
    localparam logic [6:0] E_WRLD  = 7'b0001100;
    localparam logic [6:0] E_WRREQ = 7'b1100100;
    localparam logic [6:0] E_DONE  = 7'b0000110;
    localparam logic [6:0] E_ABORT = 7'b0000101;

    mdr_access_controller #(.MAX_WAIT(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_start(rd_start), .wr_start(wr_start), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .MMD(MMD), .SMD(SMD),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Minimal MDR datapath driven by the DUT selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   mdr <= 8'h00;
        else if (SMD) mdr <= sbus;
        else if (MMD) mdr <= mbus;
    end

    function automatic logic [6:0] outs();
        return {mem_req, mem_we, MMD, SMD, busy, done, timeout_err};
    endfunction

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic rd, input logic wr,
                        input logic ack, input logic [6:0] exp);
        logic [6:0] e;
        rd_start = rd;
        wr_start = wr;
        mem_ack  = ack;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {1'b0, outs()}, {1'b0, e});
    endtask

    initial begin
        rst_n = 1'b0; rd_start = 1'b0; wr_start = 1'b0; mem_ack = 1'b0;
        mbus = 8'h11; sbus = 8'h22;
        #12;
        check("rst_outs", {1'b0, outs()}, {1'b0, E_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_idle", 0, 0, 0, E_IDLE);

        // Read, ack on first request cycle
        step("rd1_req", 1, 0, 0, E_RDREQ);
        mbus = 8'hC3;
        step("rd1_lat", 0, 0, 1, E_RDLAT);
        step("rd1_done", 0, 0, 0, E_DONE);
        mbus = 8'h00;
        step("rd1_idle", 0, 0, 0, E_IDLE);
        check("rd1_mdr", mdr, 8'hC3);

        // Store, ack delayed to the 4th request cycle
        step("wr_load", 0, 1, 0, E_WRLD);
        sbus = 8'hA5;
        step("wr_req0", 0, 0, 0, E_WRREQ);
        sbus = 8'h3C;
        for (int i = 0; i < 3; i++) step("wr_reqn", 0, 0, 0, E_WRREQ);
        step("wr_done", 0, 0, 1, E_DONE);
        step("wr_idle", 0, 0, 0, E_IDLE);
        check("wr_mdr", mdr, 8'hA5);

        // Timeout: 8 request cycles without ack
        mbus = 8'hEE;
        step("to_req0", 1, 0, 0, E_RDREQ);
        for (int i = 0; i < 7; i++) step("to_reqn", 0, 0, 0, E_RDREQ);
        step("to_abort", 0, 0, 0, E_ABORT);
        step("to_idle", 0, 0, 0, E_IDLE);
        check("to_mdr", mdr, 8'hA5);

        // Ack in the 8th (last allowed) request cycle
        step("last_req0", 1, 0, 0, E_RDREQ);
        for (int i = 0; i < 7; i++) step("last_reqn", 0, 0, 0, E_RDREQ);
        mbus = 8'h5A;
        step("last_lat", 0, 0, 1, E_RDLAT);
        step("last_done", 0, 0, 0, E_DONE);
        step("last_idle", 0, 0, 0, E_IDLE);
        check("last_mdr", mdr, 8'h5A);

        // Simultaneous starts, wr_start while busy, stray ack in IDLE
        step("both_req", 1, 1, 0, E_RDREQ);
        step("both_lat", 0, 1, 1, E_RDLAT);
        step("both_done", 0, 1, 0, E_DONE);
        step("both_idle", 0, 0, 0, E_IDLE);
        step("ack_idle", 0, 0, 1, E_IDLE);

        // Async reset in the middle of WR_REQ
        step("rr_load", 0, 1, 0, E_WRLD);
        step("rr_req", 0, 0, 0, E_WRREQ);
        step("rr_req1", 0, 0, 0, E_WRREQ);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_async", {1'b0, outs()}, {1'b0, E_IDLE});
        @(posedge clk);
        #1;
        check("rr_held", {1'b0, outs()}, {1'b0, E_IDLE});
        rst_n = 1'b1;
        step("rr_idle0", 0, 0, 1, E_IDLE);
        step("rr_idle1", 0, 0, 0, E_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdr_access_controller.md
Name: mdr_access_controller

Overview:
Sequencer for the MDR and its memory handshake. Drives the MDR source selects MMD (load from M bus) and SMD (load from S bus). Runs read transactions (memory -> M bus -> MDR) and store transactions (S bus -> MDR -> memory) for the control unit, including a wait-state timeout. Sits between the control unit and the MDR datapath / memory interface.

Parameters:
MAX_WAIT, 8, maximum number of cycles to wait for mem_ack in a request state before aborting (legal range 1..255)
CNT_W, 8, width of the wait counter (must be able to hold MAX_WAIT)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_start  input  1  control unit requests a memory read into MDR; sampled only in IDLE
wr_start  input  1  control unit requests a store of the S bus value to memory via MDR; sampled only in IDLE
mem_ack  input  1  memory acknowledge; completes the current mem_req
mem_req  output  1  memory request, held until ack or timeout
mem_we  output  1  memory write enable, valid while mem_req=1
MMD  output  1  MDR load-from-M-bus select
SMD  output  1  MDR load-from-S-bus select
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
timeout_err  output  1  one-cycle pulse on timeout abort

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n). Assertion forces IDLE and clears the wait counter immediately, including mid-transaction. No partial completion: no done and no timeout_err pulse.
- Moore outputs, decoded from the state register only. Reset values: all outputs 0.
- States and transitions:
  - IDLE: all outputs 0.
    - rd_start=1 -> RD_REQ. Read has priority when rd_start and wr_start are both 1 in the same cycle; wr_start is dropped.
    - else wr_start=1 -> WR_LOAD.
  - RD_REQ: mem_req=1, mem_we=0.
    - mem_ack=1 -> RD_LATCH.
    - else if wait counter = MAX_WAIT-1 -> ABORT.
    - else counter increments.
  - RD_LATCH: MMD=1 for exactly one cycle, so the MDR captures the M bus. Next state DONE.
  - WR_LOAD: SMD=1 for exactly one cycle, so the MDR captures the S bus. Next state WR_REQ.
  - WR_REQ: mem_req=1, mem_we=1. Same ack and timeout rule as RD_REQ.
    - mem_ack -> DONE.
    - timeout -> ABORT.
  - DONE: done=1 for one cycle, then IDLE.
  - ABORT: timeout_err=1 for one cycle, then IDLE. MDR keeps its contents (MMD=SMD=0).
- Wait counter:
  - cleared on entry to RD_REQ/WR_REQ.
  - counts cycles spent in the request state with mem_ack=0.
  - The request state is held for at most MAX_WAIT cycles.
  - mem_ack in the last allowed cycle counts as success; ack wins over timeout in that cycle.
- mem_ack outside RD_REQ/WR_REQ is ignored.
- Invariants, checked by assertion:
  - MMD and SMD are never both 1.
  - MMD/SMD never high while mem_req=1.
  - mem_we=1 implies mem_req=1.
  - done and timeout_err are never both 1.
- Latency, counted from the start cycle (= cycle 0, IDLE):
  - Read with ack in the first RD_REQ cycle: mem_req at cycle 1, MMD at cycle 2, done at cycle 3, IDLE at cycle 4.
  - Store with ack in the first WR_REQ cycle: SMD at cycle 1, mem_req+mem_we at cycle 2, done at cycle 3.
- Start requests while busy=1 are ignored, not queued.

Test Plan:
- Reset: assert rst_n=0 during WR_REQ -> all outputs 0 immediately; after release, state IDLE, busy=0, no done or timeout_err pulse.
- Read with ack on first cycle: rd_start pulse at cycle 0 -> mem_req=1 (mem_we=0) at cycle 1, MMD=1 at cycle 2, done=1 at cycle 3, busy=0 at cycle 4.
- Store with ack delayed 3 cycles: wr_start at cycle 0 -> SMD=1 at cycle 1, mem_req=mem_we=1 for cycles 2-5 (ack at 5), done at cycle 6; MDR holds the S bus value present at cycle 1.
- Timeout, MAX_WAIT=8, ack never asserted: rd_start -> mem_req high for exactly 8 cycles, then timeout_err=1 for one cycle, MMD never asserted, IDLE next.
- Ack on last allowed cycle, MAX_WAIT=8, ack in the 8th RD_REQ cycle -> RD_LATCH taken, done pulse, no timeout_err.
- Simultaneous rd_start=wr_start=1 in IDLE -> read sequence only; wr_start pulsed while busy -> ignored (no SMD).
